// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner with a double-buffered display word,
// per-slot dead time, 4-bit PWM brightness and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int REFRESH_CLOCKS = 200_000,
    parameter int BLANK_CLOCKS   = 2_000,
    parameter bit LZ_SUPPRESS    = 1'b0
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [4*N_DIGITS-1:0]   i_data,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic [N_DIGITS-1:0]     i_blank,
    input  logic [3:0]              i_bright,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [N_DIGITS-1:0]     o_an,
    output logic                    o_frame
);

    localparam int SW = $clog2(REFRESH_CLOCKS);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_CLOCKS - 1);
    localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CLOCKS);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [SW-1:0]           r_slot;
    logic [IW-1:0]           r_idx;
    logic [3:0]              r_pwm;
    logic [4*N_DIGITS-1:0]   r_act_data, r_pend_data;
    logic [N_DIGITS-1:0]     r_act_dp, r_pend_dp;
    logic [N_DIGITS-1:0]     r_act_blank, r_pend_blank;
    logic                    r_pend_full;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [N_DIGITS-1:0]     w_hi_zero;
    logic [3:0]              w_nib;
    logic                    w_blanked;
    logic                    w_lit;
    logic [N_DIGITS-1:0]     w_an_d;
    logic [6:0]              w_seg_d;
    logic                    w_dp_d;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    assign o_ready     = !r_pend_full;
    assign w_slot_end  = (r_slot == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_slot       <= '0;
            r_idx        <= '0;
            r_pwm        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_full  <= 1'b0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (w_slot_end) begin
                r_slot <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_slot <= r_slot + SW'(1);
            end
            // Acceptance only happens while pending is empty, so it never races the copy.
            if (w_frame_end && r_pend_full) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_pend_full <= 1'b0;
            end
            if (i_valid && o_ready) begin
                r_pend_data  <= i_data;
                r_pend_dp    <= i_dp;
                r_pend_blank <= i_blank;
                r_pend_full  <= 1'b1;
            end
        end
    end

    // w_hi_zero[d]: every active nibble at index >= d is zero.
    always_comb begin
        logic v_acc;
        v_acc     = 1'b1;
        w_hi_zero = '0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            v_acc        = v_acc && (r_act_data[4*d +: 4] == 4'd0);
            w_hi_zero[d] = v_acc;
        end
    end

    always_comb begin
        w_nib     = r_act_data[{r_idx, 2'b00} +: 4];
        w_blanked = r_act_blank[r_idx] ||
                    (LZ_SUPPRESS && (r_idx != '0) && w_hi_zero[r_idx]);
        w_lit     = (r_slot >= SLOT_BLANK) &&
                    ((i_bright == 4'hF) || (r_pwm < i_bright)) && !w_blanked;
    end

    always_comb begin
        w_an_d  = '1;
        w_seg_d = 7'h7F;
        w_dp_d  = 1'b1;
        if (w_lit) begin
            w_an_d[r_idx] = 1'b0;
            w_seg_d       = f_glyph(w_nib);
            w_dp_d        = !r_act_dp[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_an    <= '1;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            o_an    <= w_an_d;
            o_seg   <= w_seg_d;
            o_dp    <= w_dp_d;
            o_frame <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (leading-zero blanking off/on) against a
// cycle-count based display model, plus literal pins for the documented scenarios.
module tb_seg7_scan_ctrl;
    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst = 1'b1, i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic [3:0]  i_dp = '0, i_blank = '0, i_bright = 4'hF;
    logic        o_ready0, o_ready1, o_dp0, o_dp1, o_frame0, o_frame1;
    logic [6:0]  o_seg0, o_seg1;
    logic [3:0]  o_an0, o_an1;

    seg7_scan_ctrl #(.N_DIGITS(N), .REFRESH_CLOCKS(R), .BLANK_CLOCKS(B), .LZ_SUPPRESS(1'b0)) u_dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
        .i_dp(i_dp), .i_blank(i_blank), .i_bright(i_bright), .o_seg(o_seg0), .o_dp(o_dp0),
        .o_an(o_an0), .o_frame(o_frame0));

    seg7_scan_ctrl #(.N_DIGITS(N), .REFRESH_CLOCKS(R), .BLANK_CLOCKS(B), .LZ_SUPPRESS(1'b1)) u_lz (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data),
        .i_dp(i_dp), .i_blank(i_blank), .i_bright(i_bright), .o_seg(o_seg1), .o_dp(o_dp1),
        .o_an(o_an1), .o_frame(o_frame1));

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  glyph [16];
    // Model: c counts clocks since reset; slot, digit and pwm follow from it arithmetically.
    int          c = 0;
    int          last_c = -1;
    logic [15:0] m_act_data = '0, m_pend_data = '0;
    logic [3:0]  m_act_dp = '0, m_act_blank = '0, m_pend_dp = '0, m_pend_blank = '0;
    bit          m_pend_full = 1'b0;
    logic [3:0]  e_an [2];
    logic [6:0]  e_seg [2];
    logic        e_dp [2];
    logic        e_frame, e_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (c=%0d): got %0h, expected %0h", name, last_c, act, exp);
        end
    endtask

    function automatic bit blanked(input int d, input bit lz);
        return m_act_blank[d] || (lz && d > 0 && (m_act_data >> (4 * d)) == 16'd0);
    endfunction

    task automatic model_advance();
        logic [3:0] one;
        one = 4'b0001;
        if (i_rst) begin
            c = 0; last_c = -1;
            m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0; m_pend_full = 1'b0;
            for (int k = 0; k < 2; k++) begin
                e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
            end
            e_frame = 1'b0; e_ready = 1'b1;
        end else begin
            int  slot, idx, pwm;
            bit  lit, acc;
            slot = c % R; idx = (c / R) % N; pwm = c % 16;
            for (int k = 0; k < 2; k++) begin
                lit = slot >= B && (i_bright == 4'hF || pwm < int'(i_bright)) &&
                      !blanked(idx, k[0]);
                e_an[k]  = lit ? ~(one << idx) : 4'hF;
                e_seg[k] = lit ? glyph[m_act_data[idx*4 +: 4]] : 7'h7F;
                e_dp[k]  = lit ? ~m_act_dp[idx] : 1'b1;
            end
            e_frame = (c % (R * N)) == R * N - 1;
            acc = i_valid && !m_pend_full;
            if (e_frame && m_pend_full) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                m_pend_full = 1'b0;
            end
            if (acc) begin
                m_pend_data = i_data; m_pend_dp = i_dp; m_pend_blank = i_blank;
                m_pend_full = 1'b1;
            end
            e_ready = !m_pend_full;
            last_c = c;
            c++;
        end
    endtask

    task automatic compare_all();
        chk("an", o_an0, e_an[0]);     chk("an_lz", o_an1, e_an[1]);
        chk("seg", o_seg0, e_seg[0]);  chk("seg_lz", o_seg1, e_seg[1]);
        chk("dp", o_dp0, e_dp[0]);     chk("dp_lz", o_dp1, e_dp[1]);
        chk("frame", o_frame0, e_frame); chk("frame_lz", o_frame1, e_frame);
        chk("ready", o_ready0, e_ready); chk("ready_lz", o_ready1, e_ready);
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        int k;
        k = 0;
        while (!o_ready0 && k < 80) begin
            tick();
            k++;
        end
        if (!o_ready0) begin
            n_checks++; n_fail++;
            $display("FAIL send_wait: o_ready still 0 after %0d clocks, required 1", k);
        end
        i_valid = 1'b1; i_data = d; i_dp = dp; i_blank = bl;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic reset_and_pin();
        i_rst = 1'b1; i_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        chk("rst_ready", o_ready0, 1); chk("rst_an", o_an0, 4'hF);
        chk("rst_seg", o_seg0, 7'h7F); chk("rst_dp", o_dp0, 1); chk("rst_frame", o_frame0, 0);
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        logic [15:0] mask;
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                  7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        @(negedge clk);
        reset_and_pin();

        // Load 1234 straight after reset; visible from the first frame boundary.
        i_valid = 1'b1; i_data = 16'h1234; i_dp = '0; i_blank = '0; i_bright = 4'hF;
        tick();
        i_valid = 1'b0;
        chk("ready_after_accept", o_ready0, 0);
        for (int k = 0; k < 70; k++) begin
            tick();
            if (last_c == 30) chk("pin_noframe30", o_frame0, 0);
            if (last_c == 31) chk("pin_frame31", o_frame0, 1);
            if (last_c == 33) chk("pin_deadtime", o_an0, 4'hF);
            if (last_c == 34) begin
                chk("pin_an_d0", o_an0, 4'b1110); chk("pin_seg_4", o_seg0, 7'b0011001);
            end
            if (last_c == 42) begin
                chk("pin_an_d1", o_an0, 4'b1101); chk("pin_seg_3", o_seg0, 7'b0110000);
            end
            if (last_c == 50) chk("pin_an_d2", o_an0, 4'b1011);
            if (last_c == 58) begin
                chk("pin_an_d3", o_an0, 4'b0111); chk("pin_seg_1", o_seg0, 7'b1111001);
            end
        end

        // Back-to-back words: second one stalls until the boundary.
        i_valid = 1'b1; i_data = 16'hABCD;
        tick();
        i_data = 16'h5678;
        tick();
        chk("stall_ready", o_ready0, 0);
        for (int k = 0; k < 40; k++) tick();
        i_valid = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (o_frame0) cnt_a++;
        end
        chk("frame_rate", cnt_a, 2);

        // Leading-zero blanking.
        send(16'h0050, 4'h0, 4'h0);
        for (int k = 0; k < 40; k++) tick();
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (o_an1 == 4'b1110 && o_seg1 == 7'b1000000) cnt_a++;
            if (o_an1 == 4'b1101 && o_seg1 == 7'b0010010) cnt_b++;
            if (o_an1[3:2] != 2'b11) cnt_c++;
        end
        chk("lz_d0_zero", cnt_a, 6); chk("lz_d1_five", cnt_b, 6); chk("lz_hi_dark", cnt_c, 0);
        send(16'h0000, 4'h0, 4'h0);
        for (int k = 0; k < 40; k++) tick();
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (o_an1 == 4'b1110) cnt_a++;
            if (o_an1 != 4'b1110 && o_an1 != 4'hF) cnt_b++;
        end
        chk("lz0_d0_lit", cnt_a, 6); chk("lz0_others_dark", cnt_b, 0);

        // Brightness.
        send(16'h1234, 4'h0, 4'h0);
        for (int k = 0; k < 40; k++) tick();
        i_bright = 4'd4;
        tick();
        cnt_a = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (o_an0 != 4'hF) cnt_a++;
        end
        chk("bright4_lit", cnt_a, 4);
        i_bright = 4'd0;
        tick();
        cnt_a = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (o_an0 != 4'hF) cnt_a++;
        end
        chk("bright0_lit", cnt_a, 0);
        i_bright = 4'hF;

        // Decimal point and forced blank.
        send(16'h1234, 4'b0010, 4'b1000);
        for (int k = 0; k < 40; k++) tick();
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (!o_dp0) cnt_a++;
            if (!o_an0[3]) cnt_b++;
        end
        chk("dp_window", cnt_a, 6); chk("blank_d3", cnt_b, 0);

        // Reset mid-frame with a word pending.
        cnt_a = 0;
        while (!o_frame0 && cnt_a < 40) begin
            tick();
            cnt_a++;
        end
        chk("frame_seen", o_frame0, 1);
        send(16'h8888, 4'hF, 4'h0);
        for (int k = 0; k < 3; k++) tick();
        chk("pend_before_rst", o_ready0, 0);
        reset_and_pin();
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (o_seg0 == 7'b0000000 || !o_dp0) cnt_a++;
            if (k >= 32 && o_an0 == 4'b1110 && o_seg0 == 7'b1000000) cnt_b++;
        end
        chk("discarded_never_shown", cnt_a, 0); chk("post_rst_zero", cnt_b, 6);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            i_rst   = ($urandom_range(0, 399) == 0);
            i_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            i_data  = 16'($urandom) & mask;
            i_dp    = 4'($urandom);
            i_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0)
                i_bright = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            tick();
        end
        i_rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 SHALL have parameter REFRESH_CLOCKS, default 200_000: clocks per digit slot, minimum 4.
REQ-003 SHALL have parameter BLANK_CLOCKS, default 2_000: dead-time clocks at the start of each slot, legal range 1..REFRESH_CLOCKS-1.
REQ-004 SHALL have parameter LZ_SUPPRESS, default 0: 1 enables leading-zero blanking.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_valid, input, 1 bit: new display word offered.
REQ-008 SHALL have port o_ready, output, 1 bit: pending buffer empty, word accepted when i_valid && o_ready.
REQ-009 SHALL have port i_data, input, 4*N_DIGITS bits: hex nibbles; digit d = i_data[4d+3:4d].
REQ-010 SHALL have port i_dp, input, N_DIGITS bits: decimal point per digit, 1 = lit.
REQ-011 SHALL have port i_blank, input, N_DIGITS bits: forced blank per digit, 1 = dark.
REQ-012 SHALL have port i_bright, input, 4 bits: brightness, 0 = off, 15 = full; sampled live.
REQ-013 SHALL have port o_seg, output, 7 bits: active-low segments, o_seg[0]=CA .. o_seg[6]=CG.
REQ-014 SHALL have port o_dp, output, 1 bit: active-low decimal point.
REQ-015 SHALL have port o_an, output, N_DIGITS bits: active-low anodes, at most one low.
REQ-016 SHALL have port o_frame, output, 1 bit: one-cycle pulse when a new frame starts.

Function
REQ-017 SHALL run a slot counter 0..REFRESH_CLOCKS-1; at REFRESH_CLOCKS-1 it wraps to 0 and the digit index advances d -> d+1, with N_DIGITS-1 -> 0.
REQ-018 SHALL run a free-running 4-bit PWM counter, incrementing every clock and wrapping 15 -> 0.
REQ-019 SHALL drive anode d low iff all of: digit index == d; slot counter >= BLANK_CLOCKS; (i_bright == 15 || pwm < i_bright); digit d not blanked.
REQ-020 SHALL treat digit d as blanked if active i_blank[d] = 1, or LZ_SUPPRESS = 1 and d > 0 and every active nibble at index >= d is 0.
REQ-021 SHALL decode nibbles to glyphs 0-9, A, b, C, d, E, F, with {CG..CA} as 0-3 = 1000000, 1111001, 0100100, 0110000; 4-7 = 0011001, 0010010, 0000010, 1111000; 8-B = 0000000, 0010000, 0001000, 0000011; C-F = 1000110, 0100001, 0000110, 0001110.
REQ-022 SHALL drive o_seg = 7'h7F and o_dp = 1 whenever all anodes are high.
REQ-023 SHALL register o_seg, o_dp, o_an and o_frame, giving 1-cycle latency from counter, index and active-register state.
REQ-024 SHALL store an accepted word (i_data, i_dp, i_blank) in a pending register and deassert o_ready on the next cycle.
REQ-025 SHALL copy pending to the active registers at the frame boundary (slot == REFRESH_CLOCKS-1 and index == N_DIGITS-1), with o_ready high on the following cycle.
REQ-026 SHALL have no bypass: a word accepted on the boundary cycle itself waits until the next boundary.
REQ-027 SHALL leave active registers unchanged at a boundary when pending is empty.
REQ-028 SHALL pulse o_frame on the cycle after every frame boundary.

Reset
REQ-029 SHALL, on i_rst, clear the slot counter, digit index, PWM counter, active and pending registers, and the pending flag.
REQ-030 SHALL, on the cycle after i_rst, show o_ready = 1, o_an all 1, o_seg = 7'h7F, o_dp = 1, o_frame = 0.
REQ-031 SHALL let reset mid-frame discard any pending word and restart from digit 0, slot 0.

Verification (N_DIGITS=4, REFRESH_CLOCKS=8, BLANK_CLOCKS=2, i_bright=15)
REQ-032 SHALL cover: load 16'h1234 after reset -> shown from the first frame boundary; digit 0 shows o_seg = 7'b0011001 ("4") for slots 2-7 and dark for slots 0-1; o_an steps 1110, 1101, 1011, 0111.
REQ-033 SHALL cover: two back-to-back i_valid words -> second stalls (o_ready = 0) until the boundary; o_frame pulses once per 32 clocks.
REQ-034 SHALL cover: LZ_SUPPRESS=1, data 16'h0050 -> digits 2 and 3 dark, digit 1 shows "5", digit 0 shows "0"; data 16'h0000 -> only digit 0 lit.
REQ-035 SHALL cover: i_bright = 4 -> on the enabled slot, anode low exactly when pwm is 0..3; i_bright = 0 -> o_an = 4'hF throughout.
REQ-036 SHALL cover: i_dp = 4'b0010, i_blank = 4'b1000 -> o_dp = 0 only in digit 1's lit window; digit 3 never lit.
REQ-037 SHALL cover: i_rst asserted mid-frame with a word pending -> all REQ-030 values hold; the pending word is never displayed.
